// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the scanned 7-segment display driver.
//   SEG_0..SEG_F : active-low glyphs in {dp,g,f,e,d,c,b,a} order, dp dark
//   SEG_BLANK    : all segments dark
//   AN_OFF       : all digit enables inactive
//   digit_t      : one packed-BCD/hex nibble
//   disp_t       : one full display image (decimal points + 8 nibbles)
package seg_pkg;

    typedef logic [3:0] digit_t;

    typedef struct packed {
        logic [7:0]  dp;
        logic [31:0] bcd;
    } disp_t;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] AN_OFF    = 8'hFF;

endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational nibble to active-low 7-segment glyph.
//   nibble : input digit 0..15 (10..15 shown as A..F)
//   glyph  : {g,f,e,d,c,b,a}, active-low
module hex_to_seg
    import seg_pkg::*;
(
    input  digit_t     nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_BLANK[6:0];
        case (nibble)
            4'h0: glyph = SEG_0[6:0];
            4'h1: glyph = SEG_1[6:0];
            4'h2: glyph = SEG_2[6:0];
            4'h3: glyph = SEG_3[6:0];
            4'h4: glyph = SEG_4[6:0];
            4'h5: glyph = SEG_5[6:0];
            4'h6: glyph = SEG_6[6:0];
            4'h7: glyph = SEG_7[6:0];
            4'h8: glyph = SEG_8[6:0];
            4'h9: glyph = SEG_9[6:0];
            4'hA: glyph = SEG_A[6:0];
            4'hB: glyph = SEG_B[6:0];
            4'hC: glyph = SEG_C[6:0];
            4'hD: glyph = SEG_D[6:0];
            4'hE: glyph = SEG_E[6:0];
            4'hF: glyph = SEG_F[6:0];
            default: glyph = SEG_BLANK[6:0];
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexes a 32-bit packed-BCD value onto an up-to-8-digit
// common-anode 7-segment display. New values are committed only at frame boundaries
// so a changing score never tears mid-scan.
//   clk          : system clock
//   rstn         : asynchronous reset, ACTIVE-HIGH despite the name (1 = reset)
//   bcd_in       : packed digits, nibble i = digit i
//   bcd_valid    : 1-cycle strobe capturing bcd_in/dp_in into the pending register
//   dp_in        : decimal point per digit, 1 = lit
//   blank_lz     : leading-zero blanking enable, latched at each frame boundary
//   an           : digit enables, active-low
//   seg          : {dp,g,f,e,d,c,b,a}, active-low
//   frame_done   : 1-cycle pulse in the cycle the last digit slot ends
//   busy_pending : a captured value is waiting for the next frame boundary
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned DIV_W    = 17
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] bcd_in,
    input  logic        bcd_valid,
    input  logic [7:0]  dp_in,
    input  logic        blank_lz,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        frame_done,
    output logic        busy_pending
);

    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DIGITS - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    disp_t            pend_q, pend_d;
    disp_t            disp_q, disp_d;
    logic             busy_q, busy_d;
    logic             blank_q, blank_d;
    logic [7:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;

    logic             tick;
    digit_t           cur_nib;
    logic             cur_dp;
    logic [6:0]       cur_glyph;
    logic [7:0]       lz;
    logic             run;
    logic             dark;

    hex_to_seg u_hex_to_seg (
        .nibble (cur_nib),
        .glyph  (cur_glyph)
    );

    // Prescaler, digit index and pending/display bookkeeping.
    always_comb begin
        tick       = (cnt_q == CNT_LAST);
        frame_done = tick && (idx_q == IDX_LAST);

        cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end

        pend_d  = pend_q;
        busy_d  = busy_q;
        disp_d  = disp_q;
        blank_d = blank_q;
        if (frame_done) begin
            // Blanking mode is resampled every frame so it applies even when no
            // new value arrives; a same-cycle strobe bypasses the pending register.
            blank_d = blank_lz;
            busy_d  = 1'b0;
            if (bcd_valid) begin
                disp_d = '{dp: dp_in, bcd: bcd_in};
            end else if (busy_q) begin
                disp_d = pend_q;
            end
        end else if (bcd_valid) begin
            pend_d = '{dp: dp_in, bcd: bcd_in};
            busy_d = 1'b1;
        end
    end

    // lz[i] = digits i..DIGITS-1 are all zero with no decimal point lit.
    always_comb begin
        run = 1'b1;
        lz  = '0;
        for (int i = 7; i >= 0; i--) begin
            if (i < int'(DIGITS)) begin
                run   = run & (disp_q.bcd[4*i +: 4] == 4'h0) & ~disp_q.dp[i];
                lz[i] = run;
            end
        end
    end

    // Output image for the current slot; registered below for 1-cycle latency.
    always_comb begin
        cur_nib = disp_q.bcd[{idx_q, 2'b00} +: 4];
        cur_dp  = disp_q.dp[idx_q];
        dark    = blank_q && (idx_q != 3'd0) && lz[idx_q];

        an_d        = AN_OFF;
        an_d[idx_q] = 1'b0;
        seg_d       = dark ? SEG_BLANK : {~cur_dp, cur_glyph};
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            pend_q  <= '0;
            disp_q  <= '0;
            busy_q  <= 1'b0;
            blank_q <= 1'b0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_BLANK;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            disp_q  <= disp_d;
            busy_q  <= busy_d;
            blank_q <= blank_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an           = an_q;
    assign seg          = seg_q;
    assign busy_pending = busy_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: self-checking bench for seg_scan_driver (SCAN_DIV=4, DIGITS=8).
// A frame-level model tracks edges since reset release and derives slot, glyph and
// commit timing arithmetically; a compare process checks all outputs every cycle.
module tb_seg_scan_driver;

    localparam int S     = 4;
    localparam int D     = 8;
    localparam int FRAME = S * D;

    localparam logic [7:0] GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [31:0] bcd_in = '0;
    logic        bcd_valid = 1'b0;
    logic [7:0]  dp_in = '0;
    logic        blank_lz = 1'b1;
    logic [7:0]  an, seg;
    logic        frame_done, busy_pending;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .DIGITS   (D),
        .SCAN_DIV (S),
        .DIV_W    (3)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .bcd_in       (bcd_in),
        .bcd_valid    (bcd_valid),
        .dp_in        (dp_in),
        .blank_lz     (blank_lz),
        .an           (an),
        .seg          (seg),
        .frame_done   (frame_done),
        .busy_pending (busy_pending)
    );

    // ---------------- model ----------------
    logic [39:0] m_disp, m_pend;
    logic        m_busy, m_blank;
    int          m_edges;
    logic [7:0]  exp_an, exp_seg;

    task automatic model_reset();
        m_disp  = '0;
        m_pend  = '0;
        m_busy  = 1'b0;
        m_blank = 1'b0;
        m_edges = 0;
        exp_an  = 8'hFF;
        exp_seg = 8'hFF;
    endtask

    task automatic model_step();
        int         d;
        logic [3:0] nib;
        logic       dark;
        d    = (m_edges / S) % D;
        nib  = m_disp[4*d +: 4];
        dark = m_blank && (d != 0);
        for (int j = d; j < D; j++) begin
            if (m_disp[4*j +: 4] != 4'h0 || m_disp[32+j]) dark = 1'b0;
        end
        exp_an    = 8'hFF;
        exp_an[d] = 1'b0;
        exp_seg   = dark ? 8'hFF : (GLYPH[nib] & (m_disp[32+d] ? 8'h7F : 8'hFF));
        if ((m_edges % FRAME) == FRAME - 1) begin
            m_blank = blank_lz;
            if (bcd_valid) m_disp = {dp_in, bcd_in};
            else if (m_busy) m_disp = m_pend;
            m_busy = 1'b0;
        end else if (bcd_valid) begin
            m_pend = {dp_in, bcd_in};
            m_busy = 1'b1;
        end
        m_edges++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rstn);
            if (rstn) model_reset();
            else model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check("an", 40'(an), 40'(exp_an));
            check("seg", 40'(seg), 40'(exp_seg));
            check("frame_done", 40'(frame_done), 40'((m_edges % FRAME) == FRAME - 1));
            check("busy_pending", 40'(busy_pending), 40'(m_busy));
        end
    end

    task automatic wait_an(input logic [7:0] want);
        int n = 0;
        while (an !== want && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (an !== want) begin
            n_checks++;
            $display("FAIL wait_an: an=%h never reached %h", an, want);
        end
    endtask

    task automatic wait_fd();
        int n = 0;
        while (frame_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (frame_done !== 1'b1) begin
            n_checks++;
            $display("FAIL wait_fd: frame_done never seen");
        end
    endtask

    task automatic strobe(input logic [31:0] b, input logic [7:0] dp);
        bcd_in    = b;
        dp_in     = dp;
        bcd_valid = 1'b1;
        @(negedge clk);
        bcd_valid = 1'b0;
        dp_in     = '0;
    endtask

    task automatic slot_seg(input string name, input logic [7:0] a, input logic [7:0] s);
        wait_an(a);
        check(name, 40'(seg), 40'(s));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        check("rst_an", 40'(an), 40'(8'hFF));
        check("rst_seg", 40'(seg), 40'(8'hFF));
        check("rst_busy", 40'(busy_pending), 40'(0));
        rstn = 1'b0;

        // Idle: frame 1 unblanked (latch still reset), later frames blanked.
        repeat (40) @(negedge clk);
        slot_seg("idle_slot1", 8'hFD, 8'hFF);
        slot_seg("idle_slot0", 8'hFE, 8'hC0);

        // Mid-frame capture shown only after the boundary.
        strobe(32'h0000_1234, 8'h00);
        check("cap_busy", 40'(busy_pending), 40'(1));
        wait_fd();
        slot_seg("1234_s0", 8'hFE, 8'h99);
        slot_seg("1234_s3", 8'hF7, 8'hF9);
        slot_seg("1234_s4", 8'hEF, 8'hFF);

        // Back-to-back strobes: the later wins.
        strobe(32'h11, 8'h00);
        repeat (3) @(negedge clk);
        strobe(32'h22, 8'h00);
        wait_fd();
        slot_seg("22_s0", 8'hFE, 8'hA4);
        slot_seg("22_s1", 8'hFD, 8'hA4);

        // Strobe coincident with frame_done commits directly.
        wait_fd();
        strobe(32'h5, 8'h00);
        check("coinc_busy", 40'(busy_pending), 40'(0));
        slot_seg("5_s0", 8'hFE, 8'h92);

        // Decimal point stops blanking of itself and lower digits.
        strobe(32'h0, 8'h04);
        wait_fd();
        slot_seg("dp_s0", 8'hFE, 8'hC0);
        slot_seg("dp_s1", 8'hFD, 8'hC0);
        slot_seg("dp_s2", 8'hFB, 8'h40);
        slot_seg("dp_s3", 8'hF7, 8'hFF);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            bcd_valid = ($urandom_range(0, 7) == 0);
            bcd_in    = $urandom >> (4 * $urandom_range(0, 8));
            dp_in     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            blank_lz  = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bcd_valid = 1'b0;
        dp_in     = '0;
        blank_lz  = 1'b1;

        // Asynchronous reset with pending data discards everything.
        strobe(32'h9876, 8'h00);
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        #1;
        check("arst_an", 40'(an), 40'(8'hFF));
        check("arst_seg", 40'(seg), 40'(8'hFF));
        check("arst_busy", 40'(busy_pending), 40'(0));
        @(negedge clk);
        rstn = 1'b0;
        wait_fd();
        slot_seg("post_rst_s0", 8'hFE, 8'hC0);
        slot_seg("post_rst_s1", 8'hFD, 8'hFF);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
